// File: rtl/atcdmac300_ch_sched.sv
// Eight-channel DMA scheduler: two-level round-robin arbitration, valid/ready grant offer, burst-slot ownership.
// Optional build macro ATCDMAC300_SCHED_AGING_EN promotes long-waiting level-0 channels to level 1.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no slot in progress, waiting for enable and a request
// ST_ARB    | one-cycle round-robin search, winner registered into grant_ch
// ST_OFFER  | grant_valid asserted, grant held until grant_ready
// ST_ACTIVE | engine owns grant_ch, counting beats until slot end

module atcdmac300_ch_sched #(
    parameter int BURST_CNT_W = 4,
    parameter int AGE_LIMIT   = 15
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   sched_en,
    input  logic [7:0]             ch_request,
    input  logic [7:0]             ch_level,
    input  logic [BURST_CNT_W-1:0] burst_len,
    output logic                   grant_valid,
    input  logic                   grant_ready,
    output logic [2:0]             grant_ch,
    input  logic                   beat_done,
    input  logic                   ch_done,
    output logic                   busy,
    output logic [2:0]             current_channel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_OFFER  = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             grant_ch_nxt;
    logic [2:0]             current_channel_nxt;
    logic [BURST_CNT_W-1:0] beat_cnt;
    logic [BURST_CNT_W-1:0] beat_cnt_nxt;

    logic [7:0] eff_level;
    logic [7:0] l1_req;
    logic [7:0] l0_req;
    logic [7:0] search_mask;
    logic       win_found;
    logic [2:0] win_ch;
    logic       accept;
    logic       slot_end;

    assign accept   = (state == ST_OFFER) && grant_ready;
    // ch_done wins over a coincident final beat; either way it is one slot end.
    assign slot_end = (state == ST_ACTIVE) &&
                      (ch_done || (beat_done && (beat_cnt == '0)));

`ifdef ATCDMAC300_SCHED_AGING_EN
    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

    logic [3:0] age [8];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int c = 0; c < 8; c++) begin
                age[c] <= 4'd0;
            end
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (!ch_request[c] || (accept && (grant_ch == 3'(c)))) begin
                    age[c] <= 4'd0;
                end else if (accept && !ch_level[c] && (age[c] != AGE_MAX)) begin
                    age[c] <= age[c] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        eff_level = ch_level;
        for (int c = 0; c < 8; c++) begin
            if (age[c] == AGE_MAX) begin
                eff_level[c] = 1'b1;
            end
        end
    end
`else
    assign eff_level = ch_level;
`endif

    assign l1_req      = ch_request & eff_level;
    assign l0_req      = ch_request & ~eff_level;
    assign search_mask = (|l1_req) ? l1_req : l0_req;

    // Rotate from the last accepted channel; i == 8 wraps back onto it, so it is searched last.
    always_comb begin
        win_found = 1'b0;
        win_ch    = current_channel;
        for (int i = 1; i <= 8; i++) begin
            if (!win_found && search_mask[current_channel + 3'(i)]) begin
                win_found = 1'b1;
                win_ch    = current_channel + 3'(i);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state           <= ST_IDLE;
            grant_ch        <= 3'd0;
            current_channel <= 3'h7;
            beat_cnt        <= '0;
        end else begin
            state           <= state_nxt;
            grant_ch        <= grant_ch_nxt;
            current_channel <= current_channel_nxt;
            beat_cnt        <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        grant_ch_nxt        = grant_ch;
        current_channel_nxt = current_channel;
        beat_cnt_nxt        = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (sched_en && (|ch_request)) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|ch_request) begin
                    grant_ch_nxt = win_ch;
                    state_nxt    = ST_OFFER;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (grant_ready) begin
                    current_channel_nxt = grant_ch;
                    beat_cnt_nxt        = burst_len;
                    state_nxt           = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (slot_end) begin
                    state_nxt = (sched_en && (|ch_request)) ? ST_ARB : ST_IDLE;
                end else if (beat_done) begin
                    beat_cnt_nxt = beat_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign grant_valid = (state == ST_OFFER);
    assign busy        = (state == ST_ACTIVE);

endmodule

// File: tb/tb_atcdmac300_ch_sched.sv
// Directed self-checking bench for the channel scheduler.
module tb_atcdmac300_ch_sched;

    logic       hclk = 1'b0;
    logic       hreset;
    logic       sched_en;
    logic [7:0] ch_request;
    logic [7:0] ch_level;
    logic [3:0] burst_len;
    logic       grant_valid;
    logic       grant_ready;
    logic [2:0] grant_ch;
    logic       beat_done;
    logic       ch_done;
    logic       busy;
    logic [2:0] current_channel;

    int total = 0;
    int bad   = 0;

    atcdmac300_ch_sched #(.BURST_CNT_W(4), .AGE_LIMIT(15)) dut (
        .hclk(hclk), .hreset(hreset), .sched_en(sched_en),
        .ch_request(ch_request), .ch_level(ch_level), .burst_len(burst_len),
        .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_ch(grant_ch),
        .beat_done(beat_done), .ch_done(ch_done), .busy(busy),
        .current_channel(current_channel)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1; sched_en = 1'b0; ch_request = 8'h00; ch_level = 8'h00;
        burst_len = 4'd0; grant_ready = 1'b0; beat_done = 1'b0; ch_done = 1'b0;
        step(); step();
        hreset = 1'b0;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_gv got=%b exp=0", grant_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (grant_ch !== 3'd0) begin bad++; $display("FAIL rst_gch got=%0d exp=0", grant_ch); end
        total++; if (current_channel !== 3'd7) begin bad++; $display("FAIL rst_cur got=%0d exp=7", current_channel); end
    endtask

    task automatic test_single_channel();
        do_reset();
        sched_en = 1'b1; ch_request = 8'h01; burst_len = 4'd3; grant_ready = 1'b1;
        step();
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL single_n1_gv got=%b exp=0", grant_valid); end
        step();
        total++; if (grant_valid !== 1'b1 || grant_ch !== 3'd0) begin bad++; $display("FAIL single_n2 gv=%b ch=%0d exp gv=1 ch=0", grant_valid, grant_ch); end
        step();
        total++; if (busy !== 1'b1 || current_channel !== 3'd0) begin bad++; $display("FAIL single_active busy=%b cur=%0d exp 1/0", busy, current_channel); end
        beat_done = 1'b1;
        step(); step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_beat3 busy=%b exp=1", busy); end
        step();
        beat_done = 1'b0;
        total++; if (busy !== 1'b0 || grant_valid !== 1'b0) begin bad++; $display("FAIL single_beat4 busy=%b gv=%b exp 0/0", busy, grant_valid); end
        step();
        total++; if (grant_valid !== 1'b1 || grant_ch !== 3'd0) begin bad++; $display("FAIL single_regrant gv=%b ch=%0d exp 1/0", grant_valid, grant_ch); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [2:0] exp_ch;
        do_reset();
        sched_en = 1'b1; ch_request = 8'hFF; ch_level = 8'h00; grant_ready = 1'b1; ch_done = 1'b1;
        for (int s = 0; s < 9; s++) begin
            exp_ch = 3'(s % 8);
            wait_busy(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL rr_timeout slot=%0d", s); end
            else if (current_channel !== exp_ch) begin bad++; $display("FAIL rr_order slot=%0d got=%0d exp=%0d", s, current_channel, exp_ch); end
            step();
        end
        ch_done = 1'b0;
    endtask

    task automatic test_priority();
        bit ok;
        logic [2:0] exp_ch;
        do_reset();
        sched_en = 1'b1; ch_request = 8'h81; ch_level = 8'h80; grant_ready = 1'b1; ch_done = 1'b1;
        for (int s = 0; s < 18; s++) begin
`ifdef ATCDMAC300_SCHED_AGING_EN
            exp_ch = (s == 15) ? 3'd0 : 3'd7;
`else
            exp_ch = 3'd7;
`endif
            wait_busy(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL prio_timeout slot=%0d", s); end
            else if (current_channel !== exp_ch) begin bad++; $display("FAIL prio_slot slot=%0d got=%0d exp=%0d", s, current_channel, exp_ch); end
            step();
        end
        ch_done = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        sched_en = 1'b1; ch_request = 8'h08; grant_ready = 1'b0;
        step(); step();
        total++; if (grant_valid !== 1'b1 || grant_ch !== 3'd3) begin bad++; $display("FAIL stall_offer gv=%b ch=%0d exp 1/3", grant_valid, grant_ch); end
        ch_request = 8'h00; sched_en = 1'b0; ch_level = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (grant_valid !== 1'b1 || grant_ch !== 3'd3 || busy !== 1'b0) begin bad++; $display("FAIL stall_hold cyc=%0d gv=%b ch=%0d busy=%b exp 1/3/0", i, grant_valid, grant_ch, busy); end
        end
        grant_ready = 1'b1;
        step();
        total++; if (busy !== 1'b1 || grant_valid !== 1'b0 || current_channel !== 3'd3) begin bad++; $display("FAIL stall_accept busy=%b gv=%b cur=%0d exp 1/0/3", busy, grant_valid, current_channel); end
        ch_done = 1'b1;
        step();
        ch_done = 1'b0;
        step();
        total++; if (busy !== 1'b0 || grant_valid !== 1'b0) begin bad++; $display("FAIL stall_idle busy=%b gv=%b exp 0/0", busy, grant_valid); end
        ch_level = 8'h00;
    endtask

    task automatic test_simultaneous_end();
        int beats;
        do_reset();
        sched_en = 1'b1; ch_request = 8'h01; burst_len = 4'd4; grant_ready = 1'b1;
        step(); step(); step();
        beat_done = 1'b1;
        step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL simul_pre busy=%b exp=1", busy); end
        ch_done = 1'b1;
        burst_len = 4'd15;
        step();
        beat_done = 1'b0; ch_done = 1'b0;
        total++; if (busy !== 1'b0 || grant_valid !== 1'b0) begin bad++; $display("FAIL simul_arb busy=%b gv=%b exp 0/0", busy, grant_valid); end
        step();
        total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL simul_offer gv=%b exp=1", grant_valid); end
        step();
        beat_done = 1'b1;
        beats = 0;
        while (busy === 1'b1 && beats < 40) begin
            step();
            beats++;
        end
        beat_done = 1'b0;
        total++; if (beats != 16) begin bad++; $display("FAIL burst_max beats got=%0d exp=16", beats); end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        sched_en = 1'b1; ch_request = 8'h02; burst_len = 4'd7; grant_ready = 1'b1;
        step(); step(); step();
        total++; if (busy !== 1'b1 || current_channel !== 3'd1) begin bad++; $display("FAIL mid_active busy=%b cur=%0d exp 1/1", busy, current_channel); end
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        total++; if (busy !== 1'b0 || grant_valid !== 1'b0 || current_channel !== 3'd7) begin bad++; $display("FAIL mid_reset busy=%b gv=%b cur=%0d exp 0/0/7", busy, grant_valid, current_channel); end
        ch_request = 8'h80;
        step(); step();
        total++; if (grant_valid !== 1'b1 || grant_ch !== 3'd7) begin bad++; $display("FAIL mid_regrant gv=%b ch=%0d exp 1/7", grant_valid, grant_ch); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_priority();
        test_stall();
        test_simultaneous_end();
        test_reset_mid_slot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
